// File: rtl/axis_input_arbiter.sv
// Two-port AXI-Stream packet arbiter: a grant is held for a whole packet, round-robin or port-0 priority.
// Define AXIS_ARB_STATS_EN to add per-port accepted-packet counters (STAT0_PKTS / STAT1_PKTS).
module axis_input_arbiter #(
  parameter int FIXED_PRI = 0
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic [255:0] S0_AXIS_DAT_TDATA,
  input  logic         S0_AXIS_DAT_TVALID,
  input  logic [31:0]  S0_AXIS_DAT_TSTRB,
  input  logic         S0_AXIS_DAT_TLAST,
  output logic         S0_AXIS_DAT_TREADY,
  input  logic [15:0]  S0_AXIS_LEN_TDATA,
  input  logic [7:0]   S0_AXIS_SPT_TDATA,
  input  logic [7:0]   S0_AXIS_DPT_TDATA,
  input  logic         S0_AXIS_ERR_TDATA,
  input  logic [255:0] S1_AXIS_DAT_TDATA,
  input  logic         S1_AXIS_DAT_TVALID,
  input  logic [31:0]  S1_AXIS_DAT_TSTRB,
  input  logic         S1_AXIS_DAT_TLAST,
  output logic         S1_AXIS_DAT_TREADY,
  input  logic [15:0]  S1_AXIS_LEN_TDATA,
  input  logic [7:0]   S1_AXIS_SPT_TDATA,
  input  logic [7:0]   S1_AXIS_DPT_TDATA,
  input  logic         S1_AXIS_ERR_TDATA,
  output logic [255:0] M_AXIS_DAT_TDATA,
  output logic         M_AXIS_DAT_TVALID,
  output logic [31:0]  M_AXIS_DAT_TSTRB,
  output logic         M_AXIS_DAT_TLAST,
  input  logic         M_AXIS_DAT_TREADY,
  output logic [15:0]  M_AXIS_LEN_TDATA,
  output logic [7:0]   M_AXIS_SPT_TDATA,
  output logic [7:0]   M_AXIS_DPT_TDATA,
  output logic         M_AXIS_ERR_TDATA
`ifdef AXIS_ARB_STATS_EN
  ,
  output logic [31:0]  STAT0_PKTS,
  output logic [31:0]  STAT1_PKTS
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       rr_ptr;
  logic       sel0;
  logic       sel1;
  logic       last0;
  logic       last1;

  assign sel0 = (state == GRANT0);
  assign sel1 = (state == GRANT1);

  assign S0_AXIS_DAT_TREADY = sel0 & M_AXIS_DAT_TREADY;
  assign S1_AXIS_DAT_TREADY = sel1 & M_AXIS_DAT_TREADY;

  // An accepted TLAST beat closes the packet and releases the grant.
  assign last0 = S0_AXIS_DAT_TVALID & S0_AXIS_DAT_TREADY & S0_AXIS_DAT_TLAST;
  assign last1 = S1_AXIS_DAT_TVALID & S1_AXIS_DAT_TREADY & S1_AXIS_DAT_TLAST;

  always_comb begin
    M_AXIS_DAT_TDATA  = '0;
    M_AXIS_DAT_TVALID = 1'b0;
    M_AXIS_DAT_TSTRB  = '0;
    M_AXIS_DAT_TLAST  = 1'b0;
    M_AXIS_LEN_TDATA  = '0;
    M_AXIS_SPT_TDATA  = '0;
    M_AXIS_DPT_TDATA  = '0;
    M_AXIS_ERR_TDATA  = 1'b0;
    if (sel0) begin
      M_AXIS_DAT_TDATA  = S0_AXIS_DAT_TDATA;
      M_AXIS_DAT_TVALID = S0_AXIS_DAT_TVALID;
      M_AXIS_DAT_TSTRB  = S0_AXIS_DAT_TSTRB;
      M_AXIS_DAT_TLAST  = S0_AXIS_DAT_TLAST;
      M_AXIS_LEN_TDATA  = S0_AXIS_LEN_TDATA;
      M_AXIS_SPT_TDATA  = S0_AXIS_SPT_TDATA;
      M_AXIS_DPT_TDATA  = S0_AXIS_DPT_TDATA;
      M_AXIS_ERR_TDATA  = S0_AXIS_ERR_TDATA;
    end else if (sel1) begin
      M_AXIS_DAT_TDATA  = S1_AXIS_DAT_TDATA;
      M_AXIS_DAT_TVALID = S1_AXIS_DAT_TVALID;
      M_AXIS_DAT_TSTRB  = S1_AXIS_DAT_TSTRB;
      M_AXIS_DAT_TLAST  = S1_AXIS_DAT_TLAST;
      M_AXIS_LEN_TDATA  = S1_AXIS_LEN_TDATA;
      M_AXIS_SPT_TDATA  = S1_AXIS_SPT_TDATA;
      M_AXIS_DPT_TDATA  = S1_AXIS_DPT_TDATA;
      M_AXIS_ERR_TDATA  = S1_AXIS_ERR_TDATA;
    end
  end

  // rr_ptr names the port that wins a tie; it is ignored under fixed priority.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (S0_AXIS_DAT_TVALID && S1_AXIS_DAT_TVALID)
          state_nxt = ((FIXED_PRI != 0) || !rr_ptr) ? GRANT0 : GRANT1;
        else if (S0_AXIS_DAT_TVALID)
          state_nxt = GRANT0;
        else if (S1_AXIS_DAT_TVALID)
          state_nxt = GRANT1;
      end
      GRANT0:  if (last0) state_nxt = IDLE;
      GRANT1:  if (last1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state  <= IDLE;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (last0)
        rr_ptr <= 1'b1;
      else if (last1)
        rr_ptr <= 1'b0;
    end
  end

`ifdef AXIS_ARB_STATS_EN
  logic [31:0] pkt_cnt0;
  logic [31:0] pkt_cnt1;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (last0) pkt_cnt0 <= pkt_cnt0 + 32'd1;
      if (last1) pkt_cnt1 <= pkt_cnt1 + 32'd1;
    end
  end

  assign STAT0_PKTS = pkt_cnt0;
  assign STAT1_PKTS = pkt_cnt1;
`endif

endmodule

// File: doc/axis_input_arbiter.md
AXIS_INPUT_ARBITER -- requirements
Module: axis_input_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRI, default 0; 0 selects round-robin arbitration, 1 gives port 0 strict priority.
REQ-002 SHALL have port ACLK, input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-003 SHALL have port ARESET, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have, for each n in {0,1}, these slave-side ports:
- Sn_AXIS_DAT_TDATA, input, 256 bits.
- Sn_AXIS_DAT_TVALID, input, 1 bit.
- Sn_AXIS_DAT_TSTRB, input, 32 bits.
- Sn_AXIS_DAT_TLAST, input, 1 bit.
- Sn_AXIS_DAT_TREADY, output, 1 bit.
- Sn_AXIS_LEN_TDATA, input, 16 bits.
- Sn_AXIS_SPT_TDATA, input, 8 bits.
- Sn_AXIS_DPT_TDATA, input, 8 bits.
- Sn_AXIS_ERR_TDATA, input, 1 bit.
REQ-005 SHALL have the master-side ports M_AXIS_DAT_TDATA (out 256), M_AXIS_DAT_TVALID (out 1), M_AXIS_DAT_TSTRB (out 32), M_AXIS_DAT_TLAST (out 1), M_AXIS_DAT_TREADY (in 1), M_AXIS_LEN_TDATA (out 16), M_AXIS_SPT_TDATA (out 8), M_AXIS_DPT_TDATA (out 8) and M_AXIS_ERR_TDATA (out 1); these feed the stream consumed by OPED.

Function
REQ-006 SHALL implement a three-state FSM with states IDLE, GRANT0 and GRANT1.
REQ-007 In IDLE, SHALL drive all M_* outputs to 0 and S0/S1 TREADY to 0; no beat transfers in an IDLE cycle.
REQ-008 In IDLE, if any Sn TVALID=1, SHALL move to GRANTn on the next edge, chosen as follows:
- Only one port valid: that port.
- Both valid, FIXED_PRI=1: port 0.
- Both valid, FIXED_PRI=0: the port indicated by the round-robin pointer.
REQ-009 In GRANTn, SHALL pass port n through combinationally with zero latency:
- All M_* data, strobe, last and sideband outputs equal port n's inputs.
- M TVALID = Sn TVALID.
- Sn TREADY = M TREADY.
- The other port's TREADY = 0.
REQ-010 A beat SHALL be transferred only in a cycle where TVALID=1 and TREADY=1; TDATA, TSTRB and sidebands are not altered.
REQ-011 Grant SHALL be held for the whole packet; if Sn TVALID deasserts mid-packet, GRANTn is held, M TVALID=0, and the other port stays blocked.
REQ-012 An accepted beat with TLAST=1 in GRANTn SHALL return the FSM to IDLE on the next edge, and the round-robin pointer SHALL then point at the other port.
REQ-013 A single-beat packet (TLAST on its first accepted beat) SHALL occupy exactly one GRANT cycle when M TREADY=1.
REQ-014 Minimum per-packet overhead SHALL be exactly one IDLE cycle; with both ports continuously valid and M TREADY=1, output ordering SHALL be P0, P1, P0, P1 ... when FIXED_PRI=0.
REQ-015 A TVALID arriving on the ungranted port SHALL NOT interrupt the current packet; that port's TREADY stays 0 and it waits.
REQ-016 M TREADY=0 SHALL stall the granted port with no state change and no beat loss.

Reset
REQ-017 While ARESET=1 at a rising edge:
- FSM SHALL go to IDLE.
- Round-robin pointer SHALL be set to port 0.
- Statistics counters, when present, SHALL be cleared to 0.
REQ-018 From the first cycle after reset, all outputs SHALL be 0, including M TVALID, S0 TREADY and S1 TREADY.
REQ-019 Reset asserted mid-packet SHALL abandon the packet and SHALL NOT emit any further beats of it; recovering packet framing is upstream's responsibility.

Configuration
REQ-020 With macro AXIS_ARB_STATS_EN defined:
- SHALL add outputs STAT0_PKTS and STAT1_PKTS, 32 bits each.
- Each SHALL increment by 1 per accepted TLAST beat from its port, wrapping 0xFFFFFFFF -> 0.
REQ-021 Without AXIS_ARB_STATS_EN, those ports and their counter logic SHALL NOT exist, and the remaining behaviour SHALL be identical.

Verification
REQ-022 Bench SHALL cover single-port transfer: S0 sends a 4-beat packet with LEN=0x0080, SPT=0x01, DPT=0x02 and M TREADY=1 -> 4 M beats, identical data, TLAST on beat 4, sidebands 0x0080/0x01/0x02, 1 IDLE cycle before GRANT0.
REQ-023 Bench SHALL cover round-robin fairness: FIXED_PRI=0, both ports continuously offering 2-beat packets -> output packet order 0,1,0,1 and never two consecutive packets from the same port.
REQ-024 Bench SHALL cover fixed priority: FIXED_PRI=1, both ports valid -> port 0 wins every arbitration and port 1 is served only when S0 TVALID=0 in IDLE.
REQ-025 Bench SHALL cover stalls: mid-packet, M TREADY=0 for 3 cycles, then S0 TVALID=0 for 2 cycles, while S1 is valid throughout -> S1 TREADY stays 0, no beats are lost or duplicated, and the packet completes intact.
REQ-026 Bench SHALL cover reset mid-packet: ARESET=1 at beat 2 of 5 -> next cycle M TVALID=0 and both TREADY=0; after release, the next packet is arbitrated starting with port 0 priority.
REQ-027 Bench SHALL cover statistics (AXIS_ARB_STATS_EN defined): 3 packets on S0 and 2 on S1 -> STAT0_PKTS=3 and STAT1_PKTS=2; with the counter preloaded to 0xFFFFFFFF by force, one more packet -> 0.
